// File: rtl/blade_arbiter.sv
// blade_arbiter: round-robin owner of the 6-LED blade with minimum hold and contended time slice.
// Optional idle heartbeat on blade_leds[0] when BLADE_ARB_IDLE_BLINK_EN is defined.
module blade_arbiter #(
    parameter int NREQ      = 4,
    parameter int MIN_HOLD  = 2_500_000,
    parameter int SLICE     = 25_000_000
`ifdef BLADE_ARB_IDLE_BLINK_EN
    ,
    parameter int BLINK_DIV = 12_500_000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [6*NREQ-1:0] pattern,
    output logic [NREQ-1:0]   grant,
    output logic [5:0]        blade_leds,
    output logic              busy
);
    localparam int CW = $clog2(SLICE) + 1;
    localparam int LW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, HOLD, OWN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [LW-1:0] last, last_n, pick;
    logic [NREQ-1:0] grant_n, cand;
    logic found, rel;
    logic [5:0] idle_val, leds_n;
    // Candidates exclude the current owner so a handover never re-picks it.
    always_comb begin
        cand = req & ~grant;
        found = 1'b0;
        pick = last;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && cand[(int'(last) + i) % NREQ]) begin
                found = 1'b1;
                pick = LW'((int'(last) + i) % NREQ);
            end
        end
    end
    assign rel = ~|(req & grant);
    assign cnt_inc = (cnt >= CW'(SLICE)) ? cnt : cnt + 1'b1;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        last_n = last;
        grant_n = grant;
        case (state)
            IDLE: if (found) begin
                grant_n = NREQ'(1) << pick;
                last_n = pick;
                cnt_n = '0;
                state_n = HOLD;
            end
            HOLD: begin
                cnt_n = cnt_inc;
                state_n = (cnt >= CW'(MIN_HOLD - 1)) ? OWN : HOLD;
            end
            OWN: begin
                cnt_n = cnt_inc;
                if (found && (rel || cnt >= CW'(SLICE - 1))) begin
                    grant_n = NREQ'(1) << pick;
                    last_n = pick;
                    cnt_n = '0;
                    state_n = HOLD;
                end else if (rel) begin
                    grant_n = '0;
                    cnt_n = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                grant_n = '0;
                cnt_n = '0;
                state_n = IDLE;
            end
        endcase
    end
`ifdef BLADE_ARB_IDLE_BLINK_EN
    localparam int DW = $clog2(BLINK_DIV) + 1;
    logic [DW-1:0] dcnt, dcnt_n;
    logic hb, hb_n, in_idle, wrap;
    // Divider runs only across consecutive IDLE cycles, restarting at 0 on entry.
    assign in_idle = (state == IDLE) && (state_n == IDLE);
    assign wrap = dcnt == DW'(BLINK_DIV - 1);
    assign dcnt_n = !in_idle ? '0 : wrap ? '0 : dcnt + 1'b1;
    assign hb_n = in_idle && (wrap ? ~hb : hb);
    assign idle_val = {5'b0, hb_n};
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt <= '0;
            hb <= 1'b0;
        end else begin
            dcnt <= dcnt_n;
            hb <= hb_n;
        end
    end
`else
    assign idle_val = 6'b0;
`endif
    assign leds_n = (state_n == IDLE) ? idle_val : pattern[int'(last_n) * 6 +: 6];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            last <= LW'(NREQ - 1);
            grant <= '0;
            blade_leds <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            last <= last_n;
            grant <= grant_n;
            blade_leds <= leds_n;
            busy <= |grant_n;
        end
    end
endmodule

// File: doc/blade_arbiter.md
# blade_arbiter

Round-robin arbiter that shares one 6-LED blade between NREQ pattern generators (trail, counters, status displays). Each requester raises a request, and once granted its 6-bit pattern is registered onto the blade. Ownership is protected by a minimum hold time and bounded by a time slice whenever other requesters are waiting. The block sits between the pattern generators and the top-level `blade1[5:0]` pins.

## Interface
- NREQ, 4: number of requesters, 2..8.
- MIN_HOLD, 2_500_000: cycles a grant is held unconditionally (100 ms at 25 MHz), ≥1.
- SLICE, 25_000_000: cycles after which a contended owner is preempted (1 s), must be > MIN_HOLD.
- BLINK_DIV, 12_500_000: idle heartbeat half-period in cycles (used only with the macro).
- clk  in  1  25 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- pattern  in  6*NREQ  requester i pattern at bits [6i+5:6i].
- grant  out  NREQ  one-hot current owner; all-zero when idle.
- blade_leds  out  6  registered LED drive.
- busy  out  1  high while any grant is asserted.

## Operation
- Reset values: grant=0, blade_leds=0, busy=0, state=IDLE, cnt=0, last=NREQ-1 (so requester 0 has first priority).
- States:
  - IDLE: no owner.
  - HOLD: owner protected; cnt < MIN_HOLD.
  - OWN: owner may release or be preempted.
- IDLE:
  - If req≠0, select the first set req bit searching from last+1 modulo NREQ.
  - Set grant to that one-hot, set last to its index, clear cnt, go to HOLD.
- HOLD:
  - cnt increments each cycle; req of the owner is ignored.
  - When cnt reaches MIN_HOLD-1, go to OWN and keep counting.
- OWN: cnt increments, saturating at SLICE.
  - Release: the owner's req is low.
  - Preempt: cnt ≥ SLICE-1 and any other req bit is high.
  - On release or preempt, if another req is pending, hand over directly: round-robin pick from last+1, excluding the old owner, new grant on the next edge, cnt=0, HOLD. There is no idle cycle between owners.
  - On release with nothing else pending, go to IDLE with grant=0.
  - When release and preempt occur in the same cycle, the result is identical: handover.
  - An uncontended owner keeps the grant indefinitely.
- Data path:
  - Each cycle, blade_leds <= pattern slice of the owner indexed by the next-state grant. A new owner's pattern therefore appears on the same edge its grant rises.
  - In IDLE, blade_leds <= idle value (see Configuration).
- busy = |grant, registered together with grant.
- Counter width is clog2(SLICE)+1 bits, and comparisons are unsigned.
- Requests that toggle while another requester owns the blade are level-sampled only at arbitration points; there is no latching.
- rst asserted mid-ownership returns every output to its reset value on the next edge, regardless of state.

## Timing
- Arbitration latency: a req rising at edge n (IDLE) produces grant and blade_leds valid after edge n+1.
- blade_leds tracks the owner's pattern with exactly 1 cycle latency.
- Minimum ownership: MIN_HOLD cycles.
- Maximum contended ownership: SLICE cycles, plus 1 for the handover edge.
- Release latency: owner req low at edge n means the grant changes after edge n+1.
- Worst-case wait for any requester: (NREQ-1)*SLICE + NREQ cycles.
- Fully synchronous with no combinational path from req to outputs.

## Configuration
- BLADE_ARB_IDLE_BLINK_EN:
  - Defined: a BLINK_DIV-cycle divider runs only while in IDLE. In IDLE, blade_leds = {5'b0, hb}, where hb toggles every BLINK_DIV cycles starting at 0 on IDLE entry. The divider clears on leaving IDLE and on rst.
  - Undefined: the idle value is 6'b0, and the divider logic and the BLINK_DIV usage are absent.

## Test plan
Bench parameters: NREQ=4, MIN_HOLD=4, SLICE=16, BLINK_DIV=3.
- Reset: hold rst with req=4'b1111 → grant=0, blade_leds=0, busy=0. After release, first grant=4'b0001 one cycle later.
- Single requester: req=4'b0100 with pattern2=6'h2A → grant=4'b0100 and blade_leds=6'h2A after 1 cycle. Dropping req after 2 cycles still holds grant until 4 cycles have elapsed, then IDLE.
- Contention: req=4'b1011 held → grant sequence 0001 → 0010 → 1000 → 0001, each owner for 16 cycles, no idle gap.
- Voluntary release: owner 0 drops req at cycle 6 while req3 is high → grant=4'b1000 exactly 1 cycle later, and blade_leds switches to pattern3 on the same edge.
- rst mid-ownership at cycle 10 of a slice → all outputs 0 on the next edge, last reset so requester 0 wins next.
- Idle blink: with the macro defined and req=0, blade_leds alternates 6'h00 and 6'h01 every 3 cycles. Without the macro it stays 6'h00.
